// File: rtl/duckhunt_pkg.sv
// Shared definitions for the Duck Hunt shot path.
//   SCREEN_W / SCREEN_H : visible screen size in pixels
//   shot_state_t        : shot_scheduler FSM states
//   KEY_R               : HID keycode for the 'R' key (reload)
package duckhunt_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    localparam logic [7:0] KEY_R = 8'h15;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        FIRE,
        COOLDOWN,
        RELOAD
    } shot_state_t;

endpackage

// File: rtl/shot_scheduler_if.sv
// Shot request handshake between shot_scheduler and the hit-test logic.
//   shot_valid : shot request pending (master drives)
//   shot_x/y   : shot coordinates, stable while shot_valid (master drives)
//   shot_ready : hit logic accepts the shot (slave drives)
interface shot_scheduler_if;

    logic       shot_valid;
    logic [9:0] shot_x;
    logic [9:0] shot_y;
    logic       shot_ready;

    modport master (
        output shot_valid,
        output shot_x,
        output shot_y,
        input  shot_ready
    );

    modport slave (
        input  shot_valid,
        input  shot_x,
        input  shot_y,
        output shot_ready
    );

endinterface

// File: rtl/coord_clamp.sv
// Saturating clamp of a signed 32-bit coordinate into 0..MAX (10-bit result).
//   value   : signed coordinate from the SoC PIO
//   clamped : value limited to [0, MAX]
module coord_clamp #(
    parameter int MAX = 639
) (
    input  logic signed [31:0] value,
    output logic        [9:0]  clamped
);

    always_comb begin
        clamped = value[9:0];
        if (value < 0) begin
            clamped = '0;
        end else if (value > MAX) begin
            clamped = 10'(MAX);
        end
    end

endmodule

// File: rtl/shot_scheduler.sv
// Player fire sequencer: clamps the mouse crosshair to the screen, turns
// each left-button press into at most one shot over a valid/ready handshake,
// and enforces magazine count, post-shot cooldown and frame-timed reload.
//
// Ports:
//   clk, reset        : system clock, synchronous active-high reset
//   frame_tick        : one-cycle pulse at start of vertical blank
//   round_active      : fire/reload allowed only while high
//   mouse_x, mouse_y  : signed mouse position from the SoC PIO
//   mouse_button      : button bitmap, bit0 = trigger
//   keycode           : current HID keycode
//   cross_x, cross_y  : registered clamped crosshair
//   shot              : shot handshake (master side)
//   ammo              : rounds remaining
//   reloading         : high while in RELOAD
//
// Build option: define SHOT_AUTO_RELOAD_EN to go straight from FIRE to
// RELOAD when the accepted shot empties the magazine.
module shot_scheduler
    import duckhunt_pkg::*;
#(
    parameter int         SCREEN_W      = duckhunt_pkg::SCREEN_W,
    parameter int         SCREEN_H      = duckhunt_pkg::SCREEN_H,
    parameter int         AMMO_MAX      = 3,
    parameter int         COOLDOWN_CYC  = 5_000_000,
    parameter int         RELOAD_FRAMES = 30,
    parameter logic [7:0] RELOAD_KEY    = KEY_R
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                frame_tick,
    input  logic                round_active,
    input  logic signed [31:0]  mouse_x,
    input  logic signed [31:0]  mouse_y,
    input  logic        [7:0]   mouse_button,
    input  logic        [7:0]   keycode,
    output logic        [9:0]   cross_x,
    output logic        [9:0]   cross_y,
    shot_scheduler_if.master    shot,
    output logic        [1:0]   ammo,
    output logic                reloading
);

    localparam int CD_W = (COOLDOWN_CYC > 0) ? $clog2(COOLDOWN_CYC + 1) : 1;
    localparam int FR_W = (RELOAD_FRAMES > 1) ? $clog2(RELOAD_FRAMES) : 1;

    localparam logic [1:0]      AMMO_FULL = 2'(AMMO_MAX);
    localparam logic [CD_W-1:0] CD_LOAD   = CD_W'(COOLDOWN_CYC);
    localparam logic [FR_W-1:0] FR_LAST   = FR_W'(RELOAD_FRAMES - 1);

    shot_state_t     state;
    logic [CD_W-1:0] cd_cnt;
    logic [FR_W-1:0] frame_cnt;
    logic            btn_q;
    logic            trigger;
    logic            reload_req;
    logic [9:0]      clamp_x;
    logic [9:0]      clamp_y;
    logic            unused_buttons;

    assign unused_buttons = ^mouse_button[7:1];

    coord_clamp #(.MAX(SCREEN_W - 1)) u_clamp_x (
        .value   (mouse_x),
        .clamped (clamp_x)
    );

    coord_clamp #(.MAX(SCREEN_H - 1)) u_clamp_y (
        .value   (mouse_y),
        .clamped (clamp_y)
    );

    // Rising edge against last cycle's registered button: a held button
    // produces exactly one trigger regardless of the state it is seen in.
    assign trigger    = mouse_button[0] & ~btn_q;
    assign reload_req = (keycode == RELOAD_KEY) && (ammo < AMMO_FULL);

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            cd_cnt          <= '0;
            frame_cnt       <= '0;
            btn_q           <= 1'b0;
            cross_x         <= '0;
            cross_y         <= '0;
            shot.shot_valid <= 1'b0;
            shot.shot_x     <= '0;
            shot.shot_y     <= '0;
            ammo            <= AMMO_FULL;
            reloading       <= 1'b0;
        end else begin
            btn_q   <= mouse_button[0];
            cross_x <= clamp_x;
            cross_y <= clamp_y;

            case (state)
                IDLE: begin
                    if (round_active) begin
                        if (ammo == '0) begin
                            state     <= RELOAD;
                            reloading <= 1'b1;
                            frame_cnt <= '0;
                        end else begin
                            state <= ARMED;
                        end
                    end
                end

                ARMED: begin
                    if (!round_active) begin
                        state <= IDLE;
                    end else if (trigger && (ammo != '0)) begin
                        state           <= FIRE;
                        shot.shot_valid <= 1'b1;
                        shot.shot_x     <= cross_x;
                        shot.shot_y     <= cross_y;
                        ammo            <= ammo - 2'd1;
                    end else if (reload_req) begin
                        state     <= RELOAD;
                        reloading <= 1'b1;
                        frame_cnt <= '0;
                    end
                end

                // valid is never withdrawn; round_active only picks the exit
                FIRE: begin
                    if (shot.shot_ready) begin
                        shot.shot_valid <= 1'b0;
                        if (!round_active) begin
                            state <= IDLE;
`ifdef SHOT_AUTO_RELOAD_EN
                        end else if (ammo == '0) begin
                            state     <= RELOAD;
                            reloading <= 1'b1;
                            frame_cnt <= '0;
`endif
                        end else begin
                            state  <= COOLDOWN;
                            cd_cnt <= CD_LOAD;
                        end
                    end
                end

                COOLDOWN: begin
                    if (!round_active) begin
                        state  <= IDLE;
                        cd_cnt <= '0;
                    end else if (cd_cnt == '0) begin
                        state <= ARMED;
                    end else begin
                        cd_cnt <= cd_cnt - 1'b1;
                    end
                end

                RELOAD: begin
                    if (!round_active) begin
                        state     <= IDLE;
                        reloading <= 1'b0;
                        frame_cnt <= '0;
                    end else if (frame_tick) begin
                        if (frame_cnt == FR_LAST) begin
                            state     <= ARMED;
                            reloading <= 1'b0;
                            ammo      <= AMMO_FULL;
                            frame_cnt <= '0;
                        end else begin
                            frame_cnt <= frame_cnt + 1'b1;
                        end
                    end
                end

                default: begin
                    state           <= IDLE;
                    shot.shot_valid <= 1'b0;
                    reloading       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shot_scheduler.sv
// Directed bench for shot_scheduler (COOLDOWN_CYC overridden to 4).
// Expectations follow SHOT_AUTO_RELOAD_EN when it is defined for the build.
module tb_shot_scheduler;
    import duckhunt_pkg::*;

    logic               clk = 1'b0;
    logic               reset;
    logic               frame_tick;
    logic               round_active;
    logic signed [31:0] mouse_x;
    logic signed [31:0] mouse_y;
    logic        [7:0]  mouse_button;
    logic        [7:0]  keycode;
    logic        [9:0]  cross_x;
    logic        [9:0]  cross_y;
    logic        [1:0]  ammo;
    logic               reloading;

    int errors = 0;
    int checks = 0;
    int accepts;

    shot_scheduler_if sif ();

    shot_scheduler #(
        .AMMO_MAX      (3),
        .COOLDOWN_CYC  (4),
        .RELOAD_FRAMES (30),
        .RELOAD_KEY    (8'h15)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .frame_tick   (frame_tick),
        .round_active (round_active),
        .mouse_x      (mouse_x),
        .mouse_y      (mouse_y),
        .mouse_button (mouse_button),
        .keycode      (keycode),
        .cross_x      (cross_x),
        .cross_y      (cross_y),
        .shot         (sif.master),
        .ammo         (ammo),
        .reloading    (reloading)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // 30 single-cycle frame pulses, checking the last-but-one leaves reload running
    task automatic run_reload(input logic [1:0] ammo_during);
        for (int f = 1; f <= 30; f++) begin
            frame_tick = 1'b1;
            tick();
            frame_tick = 1'b0;
            tick(2);
            if (f == 29) begin
                check("reload_f29_busy", reloading, 1);
                check("reload_f29_ammo", ammo, ammo_during);
            end
        end
        check("reload_done_flag", reloading, 0);
        check("reload_done_ammo", ammo, 3);
    endtask

    initial begin
        reset          = 1'b1;
        frame_tick     = 1'b0;
        round_active   = 1'b0;
        mouse_x        = 32'sd0;
        mouse_y        = 32'sd0;
        mouse_button   = 8'h00;
        keycode        = 8'h00;
        sif.shot_ready = 1'b0;
        tick(2);
        check("rst_cross_x", cross_x, 0);
        check("rst_cross_y", cross_y, 0);
        check("rst_valid", sif.shot_valid, 0);
        check("rst_shot_x", sif.shot_x, 0);
        check("rst_shot_y", sif.shot_y, 0);
        check("rst_ammo", ammo, 3);
        check("rst_reloading", reloading, 0);
        reset = 1'b0;

        // clamp: in range, above max, negative
        mouse_x = 32'sd100; mouse_y = 32'sd50;
        tick();
        check("clamp_in_x", cross_x, 100);
        check("clamp_in_y", cross_y, 50);
        mouse_x = 32'sd1000; mouse_y = -32'sd1;
        tick();
        check("clamp_hi_x", cross_x, 639);
        check("clamp_neg_y", cross_y, 0);

        // no round: trigger ignored in IDLE
        mouse_button = 8'h01;
        tick(2);
        check("idle_no_fire", sif.shot_valid, 0);
        mouse_button = 8'h00;

        round_active = 1'b1;
        mouse_x = -32'sd5; mouse_y = 32'sd700;
        tick();
        check("tp_cross_x", cross_x, 0);
        check("tp_cross_y", cross_y, 479);
        mouse_button = 8'h01;
        tick();
        check("fire1_valid", sif.shot_valid, 1);
        check("fire1_x", sif.shot_x, 0);
        check("fire1_y", sif.shot_y, 479);
        check("fire1_ammo", ammo, 2);

        // ready low: payload stable, second press dropped
        mouse_x = 32'sd300; mouse_y = 32'sd200;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) mouse_button = 8'h00;
            if (i == 5) mouse_button = 8'h01;
            tick();
            check("hold_valid", sif.shot_valid, 1);
            check("hold_x", sif.shot_x, 0);
            check("hold_y", sif.shot_y, 479);
            check("hold_ammo", ammo, 2);
        end
        sif.shot_ready = 1'b1;
        tick();
        sif.shot_ready = 1'b0;
        check("accept1_valid", sif.shot_valid, 0);
        check("accept1_ammo", ammo, 2);

        // cooldown of 4: press in cycle 3 ignored, press in cycle 6 fires
        mouse_button = 8'h00;
        tick(3);
        mouse_button = 8'h01;
        tick();
        check("cd_early_valid", sif.shot_valid, 0);
        mouse_button = 8'h00;
        tick();
        check("cd_early_valid2", sif.shot_valid, 0);
        check("cd_early_ammo", ammo, 2);
        tick();
        mouse_button = 8'h01;
        tick();
        check("cd_fire_valid", sif.shot_valid, 1);
        check("cd_fire_x", sif.shot_x, 300);
        check("cd_fire_y", sif.shot_y, 200);
        check("cd_fire_ammo", ammo, 1);

        // held button with ready high: only the pending shot is accepted
        sif.shot_ready = 1'b1;
        accepts = 0;
        for (int i = 0; i < 1000; i++) begin
            if (sif.shot_valid && sif.shot_ready) accepts++;
            tick();
        end
        check("held_accepts", accepts, 1);
        check("held_ammo", ammo, 1);
        sif.shot_ready = 1'b0;

        mouse_button = 8'h00;
        tick();
        mouse_button = 8'h01;
        tick();
        check("fire3_valid", sif.shot_valid, 1);
        check("fire3_ammo", ammo, 0);
        mouse_button = 8'h00;
        sif.shot_ready = 1'b1;
        tick();
        sif.shot_ready = 1'b0;
        check("accept3_valid", sif.shot_valid, 0);

`ifdef SHOT_AUTO_RELOAD_EN
        check("auto_reloading", reloading, 1);
        round_active = 1'b0;
        tick();
        check("abort_reloading", reloading, 0);
        check("abort_ammo", ammo, 0);
        round_active = 1'b1;
        tick();
        check("idle_empty_reload", reloading, 1);
        run_reload(2'd0);
`else
        check("manual_no_reload", reloading, 0);
        tick(6);
        mouse_button = 8'h01;
        tick();
        check("empty_no_fire", sif.shot_valid, 0);
        check("empty_ammo", ammo, 0);
        mouse_button = 8'h00;
        keycode = 8'h15;
        tick();
        keycode = 8'h00;
        check("key_reloading", reloading, 1);
        run_reload(2'd0);
`endif

        // trigger and reload key together: trigger wins
        mouse_button = 8'h01;
        keycode = 8'h15;
        tick();
        check("both_valid", sif.shot_valid, 1);
        check("both_reloading", reloading, 0);
        check("both_ammo", ammo, 2);
        mouse_button = 8'h00;
        keycode = 8'h00;
        sif.shot_ready = 1'b1;
        tick();
        sif.shot_ready = 1'b0;
        tick(6);

        // round drops during FIRE: handshake completes, then IDLE
        mouse_button = 8'h01;
        tick();
        check("rf_fire_ammo", ammo, 1);
        round_active = 1'b0;
        tick(2);
        check("rf_valid_kept", sif.shot_valid, 1);
        sif.shot_ready = 1'b1;
        tick();
        sif.shot_ready = 1'b0;
        check("rf_accept_valid", sif.shot_valid, 0);
        mouse_button = 8'h00;
        round_active = 1'b1;
        tick();
        mouse_button = 8'h01;
        tick();
        check("rf_no_cooldown_fire", sif.shot_valid, 1);
        check("rf_ammo", ammo, 0);

        // reset mid-handshake drops valid on the next edge
        reset = 1'b1;
        tick();
        check("rst_mid_valid", sif.shot_valid, 0);
        check("rst_mid_ammo", ammo, 3);
        reset = 1'b0;
        mouse_button = 8'h00;

        // reload key with a full magazine is ignored
        tick();
        keycode = 8'h15;
        tick(2);
        check("full_key_ignored", reloading, 0);
        keycode = 8'h00;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shot_scheduler.md
# shot_scheduler

Sequences player fire requests for the Duck Hunt game: takes the NIOS-driven mouse position, mouse button and keyboard keycode PIO exports, clamps the crosshair to the visible screen, and issues at most one shot per trigger pull to the hit-detection logic over a valid/ready handshake. It enforces the magazine count, a post-shot cooldown and a frame-timed reload. It sits between the SoC PIO outputs and the game/hit-test logic in the top level.

## Interface
- SCREEN_W, 640, visible width in pixels
- SCREEN_H, 480, visible height in pixels
- AMMO_MAX, 3, rounds per magazine (1..3)
- COOLDOWN_CYC, 5_000_000, clk cycles between shots (0.1 s at 50 MHz)
- RELOAD_FRAMES, 30, frame_tick pulses a reload takes
- RELOAD_KEY, 8'h15, HID keycode that requests a reload ('R')
- clk  in  1  system clock; all logic on its rising edge
- reset  in  1  synchronous, active-high reset
- frame_tick  in  1  one-cycle pulse at start of vertical blank
- round_active  in  1  game round in progress; fire and reload allowed only while high
- mouse_x  in  32  signed mouse X from the SoC PIO
- mouse_y  in  32  signed mouse Y from the SoC PIO
- mouse_button  in  8  button bitmap; bit0 is left (trigger)
- keycode  in  8  current HID keycode from the SoC PIO
- cross_x  out  10  clamped crosshair X, registered
- cross_y  out  10  clamped crosshair Y, registered
- shot_valid  out  1  shot request pending
- shot_x  out  10  shot X, stable while shot_valid
- shot_y  out  10  shot Y, stable while shot_valid
- shot_ready  in  1  hit logic accepts the shot
- ammo  out  2  rounds remaining
- reloading  out  1  high in RELOAD state

## Operation
- Clamp: negative values go to 0; values above SCREEN_W-1 or SCREEN_H-1 go to that maximum. cross_x and cross_y are registered every cycle.
- Trigger: a rising edge of mouse_button[0], compared against the previous cycle's registered value. A held button never fires twice.
- States: IDLE, ARMED, FIRE, COOLDOWN, RELOAD.
  - IDLE: when round_active is high, go to ARMED. If ammo is 0, go to RELOAD instead.
  - ARMED: on a trigger with ammo>0, latch cross_x/cross_y into shot_x/shot_y, decrement ammo, and go to FIRE. On keycode==RELOAD_KEY with ammo<AMMO_MAX, go to RELOAD. A trigger with ammo==0 is ignored. If round_active drops, go to IDLE.
  - FIRE: shot_valid is high. On shot_valid && shot_ready, go to COOLDOWN with the counter loaded to COOLDOWN_CYC.
  - COOLDOWN: count down once per cycle; at 0, go to ARMED. If COOLDOWN_CYC is 0, go straight to ARMED on the next cycle.
  - RELOAD: count frame_tick pulses. After RELOAD_FRAMES pulses, set ammo to AMMO_MAX and go to ARMED.
- Triggers in FIRE, COOLDOWN and RELOAD are dropped, not queued.
- round_active low while in FIRE: the handshake still completes (valid is never withdrawn), then the FSM goes to IDLE instead of COOLDOWN.
- round_active low while in COOLDOWN or RELOAD: abort to IDLE; ammo is unchanged.
- Trigger and reload key in the same cycle: the trigger wins.
- ammo saturates and never wraps below 0.

## Timing
- Reset values: cross_x=0, cross_y=0, shot_valid=0, shot_x=0, shot_y=0, ammo=AMMO_MAX, reloading=0, state IDLE, counters 0.
- Trigger to shot_valid: 1 cycle. The edge is seen in cycle N and shot_valid is high in cycle N+1.
- Coordinate to cross_x/cross_y: 1 cycle.
- Shot acceptance: shot_valid falls the cycle after shot_ready is sampled high. A same-cycle ready completes the transfer in 1 cycle.
- Next shot earliest: COOLDOWN_CYC+1 cycles after acceptance.
- reset asserted mid-handshake: shot_valid drops on the next edge. Hit logic must tolerate this.

## Configuration
- SHOT_AUTO_RELOAD_EN defined: when the accepted shot leaves ammo at 0, go FIRE→RELOAD directly with no cooldown; RELOAD_KEY still works in ARMED.
- SHOT_AUTO_RELOAD_EN undefined: ammo at 0 stays in ARMED (after cooldown) until RELOAD_KEY is pressed.

## Structure
- duckhunt_pkg holds:
  - SCREEN_W and SCREEN_H defaults
  - the shot_state_t enum (IDLE, ARMED, FIRE, COOLDOWN, RELOAD)
  - the HID keycode constant KEY_R = 8'h15
- Sub-module coord_clamp: a signed 32-bit to unsigned 10-bit saturating clamp, parameterised by MAX. It is instantiated twice (X and Y).

## Test plan
- Reset, round_active=1, mouse_x=-5, mouse_y=700 → cross_x=0, cross_y=479. Pulse button 0→1 → shot_valid next cycle with shot_x=0, shot_y=479, ammo=2.
- Hold button high for 1000 cycles with shot_ready=1 → exactly one accepted shot.
- shot_ready held low 10 cycles → shot_valid and shot_x/shot_y are stable for 10 cycles. A second trigger in that window is dropped and ammo stays at 2.
- COOLDOWN_CYC=4: accept a shot, then trigger 3 cycles later → ignored. Trigger at cycle 6 → fires.
- Fire 3 shots (auto-reload off), then keycode=8'h15 → reloading=1. After 30 frame_ticks → ammo=3, reloading=0.
- With SHOT_AUTO_RELOAD_EN: 3rd accepted shot → RELOAD immediately. Drop round_active mid-reload → IDLE with ammo=0.
